// File: rtl/usb_in_ep_arbiter.sv
// Purpose: round-robin owner of the single USB IN packet buffer; muxes the owning endpoint
//          engine's put/data/done/stall onto the buffer and counts packet bytes up to MAX_PKT.
// Latency: request to grant is 1 cycle; 2 dead cycles between owners; datapath mux is combinational.
// Backpressure: puts pass only while buf_data_free is high and the packet holds fewer than MAX_PKT bytes.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   ep_req / ep_grant         per-engine request, registered one-hot grant
//   ep_data_put, ep_data,     per-engine byte strobe, byte (engine i on [8i+7:8i]),
//   ep_data_done, ep_stall    end-of-packet strobe and stall request
//   ep_data_free              broadcast: buffer has room and an owner is granted
//   ep_acked                  buf_acked routed to the owning engine only
//   buf_data_free, buf_acked  buffer space / host ACK from the IN buffer
//   buf_data_put, buf_data,   muxed write strobe, byte, end-of-packet and stall
//   buf_data_done, buf_stall  towards the buffer / protocol engine
//   buf_ep_num                registered index of the owning engine
//   pkt_len, overflow         bytes in current packet, sticky put-while-full flag
module usb_in_ep_arbiter #(
    parameter int NUM_EP  = 4,
    parameter int MAX_PKT = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_EP-1:0]     ep_req,
    output logic [NUM_EP-1:0]     ep_grant,
    input  logic [NUM_EP-1:0]     ep_data_put,
    input  logic [8*NUM_EP-1:0]   ep_data,
    input  logic [NUM_EP-1:0]     ep_data_done,
    input  logic [NUM_EP-1:0]     ep_stall,
    output logic                  ep_data_free,
    output logic [NUM_EP-1:0]     ep_acked,
    input  logic                  buf_data_free,
    input  logic                  buf_acked,
    output logic                  buf_data_put,
    output logic [7:0]            buf_data,
    output logic                  buf_data_done,
    output logic                  buf_stall,
    output logic [2:0]            buf_ep_num,
    output logic [6:0]            pkt_len,
    output logic                  overflow
);

    localparam logic [6:0] MAX_LEN = 7'(MAX_PKT);
    localparam logic [2:0] LAST_EP = 3'(NUM_EP - 1);
    localparam logic [3:0] NUM_EP4 = 4'(NUM_EP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          rr_ptr;
    logic [2:0]          rr_ptr_nxt;
    logic [NUM_EP-1:0]   grant_nxt;
    logic [2:0]          ep_num_nxt;
    logic [6:0]          pkt_len_nxt;
    logic                overflow_nxt;

    // Signals of the current owner (selected by the registered buf_ep_num).
    logic                own_req;
    logic                own_put;
    logic [7:0]          own_data;
    logic                own_done;
    logic                own_stall;

    // Round-robin search result.
    logic                win_found;
    logic [2:0]          win_idx;
    logic [3:0]          cand;

    logic                owned;
    logic                room;
    logic                accept;
    logic                ovf_hit;

    // Owner select uses constant indices so the mux stays width-clean for any NUM_EP.
    always_comb begin
        own_req   = 1'b0;
        own_put   = 1'b0;
        own_data  = 8'd0;
        own_done  = 1'b0;
        own_stall = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (buf_ep_num == 3'(i)) begin
                own_req   = ep_req[i];
                own_put   = ep_data_put[i];
                own_data  = ep_data[8*i +: 8];
                own_done  = ep_data_done[i];
                own_stall = ep_stall[i];
            end
        end
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_EP.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < NUM_EP; k++) begin
            cand = {1'b0, rr_ptr} + 4'(k);
            if (cand >= NUM_EP4) begin
                cand = cand - NUM_EP4;
            end
            for (int j = 0; j < NUM_EP; j++) begin
                if (!win_found && cand == 4'(j) && ep_req[j]) begin
                    win_found = 1'b1;
                    win_idx   = 3'(j);
                end
            end
        end
    end

    assign owned   = (state == OWNED);
    assign room    = (pkt_len < MAX_LEN);
    assign accept  = owned && own_put && buf_data_free && room;
    assign ovf_hit = owned && own_put && buf_data_free && (pkt_len == MAX_LEN);

    // Next-state logic.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_nxt    = ep_grant;
        ep_num_nxt   = buf_ep_num;
        pkt_len_nxt  = pkt_len;
        overflow_nxt = overflow | ovf_hit;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt  = OWNED;
                    grant_nxt  = {{(NUM_EP-1){1'b0}}, 1'b1} << win_idx;
                    ep_num_nxt = win_idx;
                end
            end
            OWNED: begin
                if (!own_req) begin
                    // A put/done on this last cycle was still forwarded; the count is dropped with the grant.
                    state_nxt   = RELEASE;
                    grant_nxt   = '0;
                    rr_ptr_nxt  = (buf_ep_num == LAST_EP) ? 3'd0 : buf_ep_num + 3'd1;
                    pkt_len_nxt = 7'd0;
                end else if (own_done) begin
                    // Done wins over a simultaneous put: the byte goes out, the count restarts.
                    pkt_len_nxt = 7'd0;
                end else if (accept) begin
                    pkt_len_nxt = pkt_len + 7'd1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Datapath mux; everything is held at zero unless an owner is granted.
    always_comb begin
        buf_data_put  = 1'b0;
        buf_data      = 8'd0;
        buf_data_done = 1'b0;
        buf_stall     = 1'b0;
        ep_data_free  = 1'b0;
        ep_acked      = '0;
        if (owned) begin
            buf_data_put  = accept;
            buf_data      = own_data;
            buf_data_done = own_done;
            buf_stall     = own_stall;
            ep_data_free  = buf_data_free && room;
            ep_acked      = ep_grant & {NUM_EP{buf_acked}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            rr_ptr     <= 3'd0;
            ep_grant   <= '0;
            buf_ep_num <= 3'd0;
            pkt_len    <= 7'd0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            ep_grant   <= grant_nxt;
            buf_ep_num <= ep_num_nxt;
            pkt_len    <= pkt_len_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule
